// File: rtl/adder_bist_sequencer.sv
// Built-in self-test sequencer for a WIDTH-bit adder: sweeps every operand
// combination, compares the adder's response against A+B+Cin and records results.
module adder_bist_sequencer #(
    parameter int WIDTH       = 4,
    parameter int SETTLE      = 1,
    parameter int INCLUDE_CIN = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    output logic                 cin_out,
    input  logic [WIDTH-1:0]     sum_in,
    input  logic                 cout_in,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b,
    output logic                 first_fail_cin
);

    localparam int EW = 2*WIDTH + 2;
    localparam int VW = 2*WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic [WIDTH-1:0]  r_a, r_b;
    logic              r_cin;
    logic [EW-1:0]     r_err;
    logic [EW-1:0]     w_err_next;
    logic [WIDTH-1:0]  r_ff_a, r_ff_b;
    logic              r_ff_cin;
    logic              r_busy, r_done, r_pass;
    logic              w_busy_next, w_done_next, w_pass_next;

    logic              w_start_acc;
    logic              w_last_beat;
    logic              w_last_vec;
    logic              w_compare;
    logic              w_mismatch;
    logic [WIDTH:0]    w_ref;
    logic [VW-1:0]     w_vec_inc;

    assign w_start_acc = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_beat = (r_cnt == 4'(SETTLE));
    assign w_last_vec  = (&r_a) && (&r_b) && (r_cin == 1'(INCLUDE_CIN));
    assign w_compare   = (r_state == S_DRIVE) && w_last_beat;
    assign w_ref       = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    assign w_mismatch  = ({cout_in, sum_in} != w_ref);
    // b is the innermost index, cin the outermost; the last vector wraps to zero.
    assign w_vec_inc   = {r_cin, r_a, r_b} + VW'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start)                      w_state_next = S_DRIVE;
            S_DRIVE:        if (w_last_beat && w_last_vec)  w_state_next = S_DONE;
            default:                                        w_state_next = S_IDLE;
        endcase
    end

    // Output decode, registered below so no input reaches an output combinationally
    always_comb begin
        w_err_next = r_err;
        if (w_start_acc) begin
            w_err_next = '0;
        end else if (w_compare && w_mismatch && !(&r_err)) begin
            w_err_next = r_err + EW'(1);
        end
        w_busy_next = (w_state_next == S_DRIVE);
        w_done_next = (w_state_next == S_DONE);
        w_pass_next = (w_state_next == S_DONE) && (w_err_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_err    <= '0;
            r_ff_a   <= '0;
            r_ff_b   <= '0;
            r_ff_cin <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            r_pass <= w_pass_next;
            r_err  <= w_err_next;
            if (w_start_acc) begin
                r_cnt    <= '0;
                r_a      <= '0;
                r_b      <= '0;
                r_cin    <= 1'b0;
                r_ff_a   <= '0;
                r_ff_b   <= '0;
                r_ff_cin <= 1'b0;
            end else if (r_state == S_DRIVE) begin
                if (w_last_beat) begin
                    r_cnt <= '0;
                    if (w_mismatch && (r_err == '0)) begin
                        r_ff_a   <= r_a;
                        r_ff_b   <= r_b;
                        r_ff_cin <= r_cin;
                    end
                    r_b   <= w_vec_inc[WIDTH-1:0];
                    r_a   <= w_vec_inc[2*WIDTH-1:WIDTH];
                    r_cin <= (INCLUDE_CIN != 0) ? w_vec_inc[VW-1] : 1'b0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign a_out          = r_a;
    assign b_out          = r_b;
    assign cin_out        = r_cin;
    assign err_count      = r_err;
    assign first_fail_a   = r_ff_a;
    assign first_fail_b   = r_ff_b;
    assign first_fail_cin = r_ff_cin;

endmodule

// File: tb/tb_adder_bist_sequencer.sv
// Scoreboard bench for adder_bist_sequencer: three instances with different
// SETTLE/INCLUDE_CIN settings, each driving a behavioural (optionally faulty) adder.
module tb_adder_bist_sequencer;

    localparam int NI = 3;
    localparam int SETTLE_P [NI] = '{1, 0, 3};
    localparam int CIN_P    [NI] = '{0, 1, 0};

    typedef struct {
        int         inst;
        int         cycles;
        int         err;
        logic [3:0] fa;
        logic [3:0] fb;
        logic       fc;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [NI-1:0]   start;
    logic [NI-1:0]   busy, done, pass, cin_out, cout_in, ff_cin;
    logic [3:0]      a_out  [NI];
    logic [3:0]      b_out  [NI];
    logic [3:0]      sum_in [NI];
    logic [3:0]      ff_a   [NI];
    logic [3:0]      ff_b   [NI];
    logic [9:0]      err_cnt[NI];
    int              fault  [NI];

    exp_t            exp_q[$];
    int              checks;
    int              errors;
    int              busy_cnt [NI];
    logic [NI-1:0]   prev_done;
    int              hold;
    logic [7:0]      prev_ab;
    logic            was_busy2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            logic [4:0] ideal;
            // fault 1: sum bit 0 stuck at 0; fault 2: carry-out stuck at 0
            assign ideal       = {1'b0, a_out[gi]} + {1'b0, b_out[gi]} + {4'b0, cin_out[gi]};
            assign sum_in[gi]  = (fault[gi] == 1) ? {ideal[3:1], 1'b0} : ideal[3:0];
            assign cout_in[gi] = (fault[gi] == 2) ? 1'b0 : ideal[4];

            adder_bist_sequencer #(
                .WIDTH(4), .SETTLE(SETTLE_P[gi]), .INCLUDE_CIN(CIN_P[gi])
            ) u_dut (
                .clk            (clk),
                .rst_n          (rst_n),
                .start          (start[gi]),
                .busy           (busy[gi]),
                .done           (done[gi]),
                .pass           (pass[gi]),
                .a_out          (a_out[gi]),
                .b_out          (b_out[gi]),
                .cin_out        (cin_out[gi]),
                .sum_in         (sum_in[gi]),
                .cout_in        (cout_in[gi]),
                .err_count      (err_cnt[gi]),
                .first_fail_a   (ff_a[gi]),
                .first_fail_b   (ff_b[gi]),
                .first_fail_cin (ff_cin[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pops one expectation per completed sweep and checks hold time of each vector on inst 2.
    task automatic monitor();
        exp_t e;
        logic [7:0] cur;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!rst_n) begin
                    busy_cnt[i]  = 0;
                    prev_done[i] = 1'b0;
                end else begin
                    if (busy[i] && done[i]) chk("busy_and_done", 1, 0);
                    if (busy[i]) busy_cnt[i]++;
                    if (done[i] && !prev_done[i]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_done", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            $display("sweep inst=%0d cycles=%0d err=%0d pass=%0b ff=%0d/%0d/%0d",
                                     i, busy_cnt[i], err_cnt[i], pass[i], ff_a[i], ff_b[i], ff_cin[i]);
                            chk("done_inst",   i,               e.inst);
                            chk("busy_cycles", busy_cnt[i],     e.cycles);
                            chk("err_count",   int'(err_cnt[i]), e.err);
                            chk("pass",        int'(pass[i]),   (e.err == 0) ? 1 : 0);
                            chk("first_a",     int'(ff_a[i]),   int'(e.fa));
                            chk("first_b",     int'(ff_b[i]),   int'(e.fb));
                            chk("first_cin",   int'(ff_cin[i]), int'(e.fc));
                            chk("a_idle",      int'(a_out[i]),  0);
                            chk("b_idle",      int'(b_out[i]),  0);
                        end
                        busy_cnt[i] = 0;
                    end
                    prev_done[i] = done[i];
                end
            end
            cur = {a_out[2], b_out[2]};
            if (busy[2]) begin
                if (!was_busy2) begin
                    hold = 1;
                end else if (cur != prev_ab) begin
                    chk("vector_hold", hold, 4);
                    hold = 1;
                end else begin
                    hold++;
                end
                prev_ab = cur;
            end else if (was_busy2 && rst_n) begin
                chk("last_vector_hold", hold, 4);
            end
            was_busy2 = busy[2];
        end
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", int'(done[i]), 1);
        @(negedge clk);
    endtask

    task automatic push(input int i, input int cyc, input int err,
                        input int fa, input int fb, input int fc);
        exp_t e;
        e.inst = i; e.cycles = cyc; e.err = err;
        e.fa = 4'(fa); e.fb = 4'(fb); e.fc = 1'(fc);
        exp_q.push_back(e);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; hold = 0; prev_ab = '0; was_busy2 = 1'b0;
        prev_done = '0;
        for (int i = 0; i < NI; i++) begin
            fault[i] = 0;
            busy_cnt[i] = 0;
        end
        rst_n = 1'b0;
        start = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_pass", int'(pass[0]), 0);
        chk("rst_err",  int'(err_cnt[1]), 0);
        chk("rst_a",    int'(a_out[2]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal adder, SETTLE=1: 256 vectors x 2 cycles
        push(0, 512, 0, 0, 0, 0);
        pulse_start(0);
        wait_done(0, 2000);

        // Sum bit 0 stuck at 0: every odd sum fails, first at a=0 b=1; start from DONE
        fault[0] = 1;
        push(0, 512, 128, 0, 1, 0);
        pulse_start(0);
        chk("restart_done_low", int'(done[0]), 0);
        chk("restart_busy",     int'(busy[0]), 1);
        wait_done(0, 2000);

        // Carry-out stuck at 0 with Cin sweep, SETTLE=0: 120 + 136 failures
        fault[1] = 2;
        push(1, 512, 256, 1, 15, 0);
        pulse_start(1);
        wait_done(1, 2000);

        // Asynchronous reset in the middle of a faulty sweep at a=5 b=3
        pulse_start(0);
        chk("err_cleared_on_start", int'(err_cnt[0]), 0);
        n = 0;
        while (!(a_out[0] == 4'd5 && b_out[0] == 4'd3) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_a5_b3", int'({a_out[0], b_out[0]}), 8'h53);
        chk("errors_before_reset", int'(err_cnt[0] != 0), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy[0]), 0);
        chk("async_a",    int'(a_out[0]), 0);
        chk("async_b",    int'(b_out[0]), 0);
        chk("async_err",  int'(err_cnt[0]), 0);
        chk("async_ffb",  int'(ff_b[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fault[0] = 0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", int'(busy[0]), 0);
        chk("post_rst_done", int'(done[0]), 0);
        push(0, 512, 0, 0, 0, 0);
        pulse_start(0);
        wait_done(0, 2000);

        // start while busy is ignored; busy count must still be 512
        push(0, 512, 0, 0, 0, 0);
        pulse_start(0);
        repeat (98) @(negedge clk);
        pulse_start(0);
        chk("busy_after_extra_start", int'(busy[0]), 1);
        wait_done(0, 2000);

        // SETTLE=3: every vector held 4 cycles, 1024 busy cycles
        push(2, 1024, 0, 0, 0, 0);
        pulse_start(2);
        wait_done(2, 3000);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_bist_sequencer.md
Name: adder_bist_sequencer

Overview:
- Self-test stimulus and check stage placed directly upstream of the 4-bit parallel adder.
- Drives the adder's A, B and Cin operands through every combination.
- After a configurable settle time, samples the adder's sum and carry-out and compares them with the arithmetic reference A+B+Cin.
- Reports pass/fail, an error count and the first failing vector, so the adder can be checked in silicon or in system simulation without a testbench loop.

Parameters:
WIDTH, 4, operand width; must match the adder under test.
SETTLE, 1, extra wait cycles per vector before comparing; legal range 0..15.
INCLUDE_CIN, 0, 1 = sweep Cin over {0,1}; 0 = hold Cin at 0.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE or DONE
busy  output  1  high while a sweep is in progress
done  output  1  high from sweep completion until the next accepted start
pass  output  1  valid when done=1; 1 iff err_count==0
a_out  output  WIDTH  operand A to the adder
b_out  output  WIDTH  operand B to the adder
cin_out  output  1  carry-in to the adder
sum_in  input  WIDTH  adder sum bits S[WIDTH-1:0]
cout_in  input  1  adder carry-out
err_count  output  2*WIDTH+2  number of mismatching vectors; saturates at all-ones
first_fail_a  output  WIDTH  A of the first mismatching vector
first_fail_b  output  WIDTH  B of the first mismatching vector
first_fail_cin  output  1  Cin of the first mismatching vector

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0; state=IDLE; settle counter 0. Reset asserted mid-sweep aborts immediately. After release the block sits in IDLE with done=0.
- All outputs are registered. No combinational path exists from sum_in/cout_in to any output.
- States:
  - IDLE: start=1 -> DRIVE. Clear err_count and first_fail_*; a_out=b_out=cin_out=0; busy=1.
  - DRIVE: current vector held on a_out/b_out/cin_out. Settle counter counts 0..SETTLE. Each vector therefore occupies exactly SETTLE+1 cycles.
  - Compare point: at the clock edge ending the vector's last cycle, compare {cout_in,sum_in} against the (WIDTH+1)-bit sum a_out+b_out+cin_out.
  - On mismatch: err_count increments, saturating at all-ones. If err_count was 0 before this compare, latch first_fail_a/b/cin from the current vector.
  - At that same edge, advance to the next vector. b_out is the innermost index, then a_out, then cin_out (only when INCLUDE_CIN=1). Each index wraps 2^WIDTH-1 -> 0 with carry into the next index.
  - After the last vector's compare (a=b=all-ones, cin=INCLUDE_CIN) -> DONE.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a_out/b_out/cin_out return to 0.
  - Results are held until start=1, which behaves exactly as start in IDLE and restarts the sweep.
- start while busy=1 is ignored; no restart and no counter effect.
- Vector count N = 2^(2*WIDTH) * (INCLUDE_CIN ? 2 : 1); 256 or 512 for WIDTH=4.
- Cycle count: busy rises at the edge that samples start. done rises exactly N*(SETTLE+1) cycles later. busy and done are never high together.
- err_count width 2*WIDTH+2 holds the maximum N without saturating at default widths. The saturation logic is still required for generality.

Test Plan:
1. Ideal adder model, WIDTH=4, SETTLE=1, INCLUDE_CIN=0; pulse start -> busy for exactly 512 cycles, then done=1, pass=1, err_count=0, a_out/b_out=0.
2. Model with sum bit 0 stuck at 0, INCLUDE_CIN=0 -> err_count=128, pass=0, first_fail_a=0, first_fail_b=1, first_fail_cin=0.
3. Model with carry-out stuck at 0, INCLUDE_CIN=1, SETTLE=0 -> done after 512 cycles; err_count=256 (120 failing with cin=0 + 136 with cin=1); first_fail a=1, b=15, cin=0.
4. Assert rst_n=0 for 1 cycle at vector a=5, b=3 -> all outputs 0 asynchronously, state IDLE. A new start restarts from a=b=0 with err_count=0.
5. Pulse start again at cycle 100 of a running sweep -> no effect, done still rises at the original cycle. start in DONE -> counters cleared, new sweep begins.
6. SETTLE=3, ideal model: each vector is held exactly 4 cycles, checked by monitoring a_out/b_out transitions. Total busy = 1024 cycles.
